// File: rtl/mips_regfile.sv
// 32 x 32-bit MIPS register file: one synchronous write port, two combinational read ports, R0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write data to a matching read port.
module mips_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wr_num,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd0_num,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [ADDR_W-1:0] rd1_num,
    output logic [DATA_W-1:0] rd1_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_live;

    // A write to R0 is dropped here, so regs[0] never leaves zero.
    assign wr_live = wr_en && (wr_num != '0);

    // NOTE: the whole array sits on the async reset because the core expects every register to read 0 after reset; this keeps it in flops rather than RAM macros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            // NOTE: non-blocking so every read in this cycle still sees the pre-edge contents.
            regs[wr_num] <= wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd0;
    logic fwd1;

    assign fwd0 = reset && wr_live && (rd0_num == wr_num);
    assign fwd1 = reset && wr_live && (rd1_num == wr_num);

    always_comb begin
        rd0_data = '0;
        rd1_data = '0;
        if (rd0_num != '0) begin
            rd0_data = fwd0 ? wr_data : regs[rd0_num];
        end
        if (rd1_num != '0) begin
            rd1_data = fwd1 ? wr_data : regs[rd1_num];
        end
    end
`else
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        rd0_data = '0;
        rd1_data = '0;
        if (rd0_num != '0) begin
            rd0_data = regs[rd0_num];
        end
        if (rd1_num != '0) begin
            rd1_data = regs[rd1_num];
        end
    end
`endif

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: directed vector table, hand-written reset/collision sequences,
// and a randomized run against an array-based reference model.
module tb_mips_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  wr_num;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [4:0]  rd0_num;
    logic [31:0] rd0_data;
    logic [4:0]  rd1_num;
    logic [31:0] rd1_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [6];

    mips_regfile dut (
        .clk      (clk),
        .reset    (reset),
        .wr_num   (wr_num),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd0_num  (rd0_num),
        .rd0_data (rd0_data),
        .rd1_num  (rd1_num),
        .rd1_data (rd1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge, landing 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] n, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_num  = n;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] rn, input logic we,
                                             input logic [4:0] wn, input logic [31:0] wd);
        logic [31:0] v;
        v = (rn == 5'd0) ? 32'h0 : model[rn];
`ifdef REGFILE_BYPASS_EN
        if (we && wn != 5'd0 && rn == wn) v = wd;
`endif
        return v;
    endfunction

    initial begin
        vecs[0] = '{1'b1, 5'd29, 32'h8012_0000, 5'd29, 5'd31, 32'h8012_0000, 32'h0};
        vecs[1] = '{1'b1, 5'd31, 32'h0000_0000, 5'd29, 5'd31, 32'h8012_0000, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[3] = '{1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd29, 32'hA5A5_A5A5, 32'h8012_0000};
        vecs[4] = '{1'b0, 5'd7,  32'h5A5A_5A5A, 5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[5] = '{1'b1, 5'd3,  32'h0000_0011, 5'd3,  5'd29, 32'h0000_0011, 32'h8012_0000};

        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_num  = '0;
        wr_data = '0;
        rd0_num = 5'd1;
        rd1_num = 5'd31;
        #2;
        check("reset_rd0_r1", rd0_data, 32'h0);
        check("reset_rd1_r31", rd1_data, 32'h0);

        // Writes are ignored while reset is held low.
        wr_en = 1'b1; wr_num = 5'd9; wr_data = 32'hDEAD_BEEF;
        step();
        wr_en = 1'b0;
        reset = 1'b1;
        rd0_num = 5'd9;
        #1;
        check("write_during_reset", rd0_data, 32'h0);
        step();

        // Mid-cycle reset pulse clears stored data with no clock edge.
        write_reg(5'd5, 32'h0000_1234);
        rd0_num = 5'd5;
        #1;
        check("r5_before_reset", rd0_data, 32'h0000_1234);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_r5", rd0_data, 32'h0);
        rd0_num = 5'd31;
        #1;
        check("async_reset_r31", rd0_data, 32'h0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            wr_en   = vecs[i].we;
            wr_num  = vecs[i].wnum;
            wr_data = vecs[i].wdata;
            step();
            wr_en   = 1'b0;
            rd0_num = vecs[i].r0;
            rd1_num = vecs[i].r1;
            #1;
            check($sformatf("vec%0d_rd0", i), rd0_data, vecs[i].e0);
            check($sformatf("vec%0d_rd1", i), rd1_data, vecs[i].e1);
        end

        // Full sweep, then read back pairwise through both ports.
        for (int n = 0; n < 32; n++) write_reg(5'(n), 32'h100 + 32'(n));
        for (int n = 0; n < 32; n++) begin
            rd0_num = 5'(n);
            rd1_num = 5'(31 - n);
            #1;
            check($sformatf("sweep_rd0_r%0d", n), rd0_data, (n == 0) ? 32'h0 : 32'h100 + 32'(n));
            check($sformatf("sweep_rd1_r%0d", 31 - n), rd1_data,
                  (n == 31) ? 32'h0 : 32'h100 + 32'(31 - n));
        end

        // Read/write collision on R3.
        write_reg(5'd3, 32'h11);
        wr_en = 1'b1; wr_num = 5'd3; wr_data = 32'h22;
        rd0_num = 5'd3;
        rd1_num = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("collision_pre_edge_rd0", rd0_data, 32'h22);
        check("collision_pre_edge_rd1", rd1_data, 32'h22);
`else
        check("collision_pre_edge_rd0", rd0_data, 32'h11);
        check("collision_pre_edge_rd1", rd1_data, 32'h11);
`endif
        step();
        wr_en = 1'b0;
        #1;
        check("collision_post_edge", rd0_data, 32'h22);

        for (int n = 0; n < 32; n++) model[n] = (n == 0) ? 32'h0 : 32'h100 + 32'(n);
        model[3] = 32'h22;

        // Randomized traffic against the array model; reads checked before each edge.
        for (int it = 0; it < 400; it++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_num  = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rd0_num = ($urandom_range(0, 3) == 0) ? wr_num : 5'($urandom_range(0, 31));
            rd1_num = ($urandom_range(0, 3) == 0) ? wr_num : 5'($urandom_range(0, 31));
            #1;
            check($sformatf("rand%0d_rd0", it), rd0_data, expect_rd(rd0_num, wr_en, wr_num, wr_data));
            check($sformatf("rand%0d_rd1", it), rd1_data, expect_rd(rd1_num, wr_en, wr_num, wr_data));
            if (wr_en && wr_num != 5'd0) model[wr_num] = wr_data;
            step();
        end
        wr_en = 1'b0;

        reset = 1'b0;
        #1;
        for (int n = 0; n < 32; n += 5) begin
            rd0_num = 5'(n);
            #1;
            check($sformatf("final_reset_r%0d", n), rd0_data, 32'h0);
        end
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
